// File: rtl/apb2axi_pkg.sv
// Shared types for the APB-to-AXI bridge completion path.
// Widths, response codes, the completion FIFO entry and the builder FSM states.
package apb2axi_pkg;

  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned BEAT_IDX_W = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic                  is_wr;
    logic [AXI_ID_W-1:0]   id;
    logic [1:0]            resp;
    logic [AXI_DATA_W-1:0] data;
    logic                  last;
    logic [BEAT_IDX_W-1:0] beat_idx;
    logic                  burst_err;
  } completion_t;

  typedef enum logic [0:0] {
    IDLE,
    RD_BURST
  } cmpl_state_e;

  typedef enum logic [0:0] {
    PRIO_B,
    PRIO_R
  } prio_e;

endpackage

// File: rtl/axi_completion_builder.sv
// Arbitrates AXI B and R beats into a single registered completion stream that
// feeds the Completion FIFO; one entry per accepted beat, read bursts kept contiguous.
module axi_completion_builder
  import apb2axi_pkg::*;
(
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [AXI_ID_W-1:0]   bid,
  input  logic [1:0]            bresp,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [AXI_ID_W-1:0]   rid,
  input  logic [AXI_DATA_W-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  output logic                  cmpl_valid,
  input  logic                  cmpl_ready,
  output completion_t           cmpl_entry,
  output logic                  rd_burst_act
);

  cmpl_state_e           state_q, state_d;
  prio_e                 prio_q, prio_d;
  logic [BEAT_IDX_W-1:0] beat_cnt_q, beat_cnt_d;
  logic                  err_q, err_d;
  logic                  cmpl_valid_q, cmpl_valid_d;
  completion_t           entry_q, entry_d;

  logic grant_b, grant_r;
  logic acc, b_hs, r_hs;

  // The output register can take a new beat when empty or being popped this cycle.
  assign acc    = !cmpl_valid_q | cmpl_ready;
  assign bready = acc & grant_b;
  assign rready = acc & grant_r;
  assign b_hs   = bvalid & bready;
  assign r_hs   = rvalid & rready;

  // FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (r_hs && !rlast) state_d = RD_BURST;
      RD_BURST: if (r_hs && rlast)  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM outputs: grants and burst status
  always_comb begin
    grant_b      = 1'b0;
    grant_r      = 1'b0;
    rd_burst_act = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bvalid && rvalid) begin
          grant_b = (prio_q == PRIO_B);
          grant_r = (prio_q == PRIO_R);
        end else begin
          grant_b = bvalid;
          grant_r = rvalid;
        end
      end
      RD_BURST: begin
        grant_r      = 1'b1;
        rd_burst_act = 1'b1;
      end
      default: begin
        grant_b = 1'b0;
        grant_r = 1'b0;
      end
    endcase
  end

  // Priority only rotates on contended handshakes; a finished burst hands the next turn to B.
  always_comb begin
    prio_d = prio_q;
    if (state_q == RD_BURST && r_hs && rlast) begin
      prio_d = PRIO_B;
    end else if (state_q == IDLE && bvalid && rvalid && (b_hs || r_hs)) begin
      prio_d = (prio_q == PRIO_B) ? PRIO_R : PRIO_B;
    end
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    if (r_hs) begin
      if (rlast) begin
        beat_cnt_d = '0;
        err_d      = 1'b0;
      end else begin
        if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + BEAT_IDX_W'(1);
        err_d = err_q | rresp[1];
      end
    end
  end

  // Output stage: load on accept, otherwise hold until popped.
  always_comb begin
    entry_d      = entry_q;
    cmpl_valid_d = cmpl_valid_q & !cmpl_ready;
    if (b_hs) begin
      cmpl_valid_d       = 1'b1;
      entry_d.is_wr      = 1'b1;
      entry_d.id         = bid;
      entry_d.resp       = bresp;
      entry_d.data       = '0;
      entry_d.last       = 1'b1;
      entry_d.beat_idx   = '0;
      entry_d.burst_err  = bresp[1];
    end else if (r_hs) begin
      cmpl_valid_d       = 1'b1;
      entry_d.is_wr      = 1'b0;
      entry_d.id         = rid;
      entry_d.resp       = rresp;
      entry_d.data       = rdata;
      entry_d.last       = rlast;
      entry_d.beat_idx   = beat_cnt_q;
      entry_d.burst_err  = err_q | rresp[1];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      prio_q       <= PRIO_B;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
      cmpl_valid_q <= 1'b0;
      entry_q      <= '0;
    end else begin
      prio_q       <= prio_d;
      beat_cnt_q   <= beat_cnt_d;
      err_q        <= err_d;
      cmpl_valid_q <= cmpl_valid_d;
      entry_q      <= entry_d;
    end
  end

  assign cmpl_valid = cmpl_valid_q;
  assign cmpl_entry = entry_q;

endmodule

// File: tb/tb_axi_completion_builder.sv
// Scoreboard bench for axi_completion_builder: expected entries are queued at each
// AXI handshake and compared in order as the completion stream is popped.
module tb_axi_completion_builder;
  import apb2axi_pkg::*;

  logic                  aclk = 1'b0;
  logic                  aresetn;
  logic                  bvalid, bready;
  logic [AXI_ID_W-1:0]   bid;
  logic [1:0]            bresp;
  logic                  rvalid, rready;
  logic [AXI_ID_W-1:0]   rid;
  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  cmpl_valid, cmpl_ready;
  completion_t           cmpl_entry;
  logic                  rd_burst_act;

  completion_t exp_q[$];
  completion_t log_q[$];
  int n_cmp = 0;
  int n_mis = 0;

  always #5 aclk = ~aclk;

  axi_completion_builder dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .bvalid       (bvalid),
    .bready       (bready),
    .bid          (bid),
    .bresp        (bresp),
    .rvalid       (rvalid),
    .rready       (rready),
    .rid          (rid),
    .rdata        (rdata),
    .rresp        (rresp),
    .rlast        (rlast),
    .cmpl_valid   (cmpl_valid),
    .cmpl_ready   (cmpl_ready),
    .cmpl_entry   (cmpl_entry),
    .rd_burst_act (rd_burst_act)
  );

  function automatic completion_t mk_wr(input logic [AXI_ID_W-1:0] id, input logic [1:0] resp);
    completion_t e;
    e = '0;
    e.is_wr = 1'b1; e.id = id; e.resp = resp; e.last = 1'b1; e.burst_err = resp[1];
    return e;
  endfunction

  function automatic completion_t mk_rd(input logic [AXI_ID_W-1:0] id, input logic [1:0] resp,
                                        input logic [AXI_DATA_W-1:0] data, input logic last,
                                        input int idx, input logic err);
    completion_t e;
    e = '0;
    e.id = id; e.resp = resp; e.data = data; e.last = last;
    e.beat_idx = BEAT_IDX_W'((idx > 255) ? 255 : idx);
    e.burst_err = err;
    return e;
  endfunction

  // Monitor: every pop is checked against the head of the scoreboard.
  always @(negedge aclk) begin
    completion_t exp_e;
    if (aresetn === 1'b1 && cmpl_valid === 1'b1 && cmpl_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL entry_unexpected: got %h, required no entry", cmpl_entry);
      end else begin
        exp_e = exp_q.pop_front();
        if (cmpl_entry !== exp_e) begin
          n_mis++;
          $display("FAIL entry: got %h required %h", cmpl_entry, exp_e);
        end
      end
      log_q.push_back(cmpl_entry);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic do_reset();
    bvalid = 0; rvalid = 0; rlast = 0; cmpl_ready = 1;
    bid = '0; bresp = '0; rid = '0; rdata = '0; rresp = '0;
    aresetn = 0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
    exp_q.delete();
    @(posedge aclk); #1;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge aclk);
      w++;
    end
    @(posedge aclk); #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL drain: got %0d entries outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic r_burst(input logic [AXI_ID_W-1:0] id, input int n,
                         input logic [AXI_DATA_W-1:0] base, input int err_beat,
                         input logic [1:0] ok_resp, output int stalls);
    logic err = 1'b0;
    bit got;
    stalls = 0;
    for (int k = 0; k < n; k++) begin
      rvalid = 1; rid = id;
      rdata = base + AXI_DATA_W'(k) * AXI_DATA_W'(64'h11);
      rresp = (k == err_beat) ? RESP_SLVERR : ok_resp;
      rlast = (k == n - 1);
      got = 0;
      for (int w = 0; w < 200 && !got; w++) begin
        @(negedge aclk);
        if (rready === 1'b1) got = 1;
        else stalls++;
      end
      if (!got) begin
        n_cmp++; n_mis++;
        $display("FAIL r_handshake: got rready=0 for 200 cycles, required 1");
        rvalid = 0; rlast = 0;
        return;
      end
      err = err | rresp[1];
      exp_q.push_back(mk_rd(id, rresp, rdata, rlast, k, err));
      n_cmp++;
      if (rd_burst_act !== (k > 0)) begin
        n_mis++;
        $display("FAIL rd_burst_act beat %0d: got %b required %b", k, rd_burst_act, (k > 0));
      end
      @(posedge aclk); #1;
    end
    rvalid = 0; rlast = 0;
  endtask

  task automatic b_stream(input int n, input logic [AXI_ID_W-1:0] id0, input logic [1:0] resp);
    bit got;
    for (int i = 0; i < n; i++) begin
      bvalid = 1; bid = id0 + AXI_ID_W'(i); bresp = resp;
      got = 0;
      for (int w = 0; w < 200 && !got; w++) begin
        @(negedge aclk);
        if (bready === 1'b1) got = 1;
      end
      if (!got) begin
        n_cmp++; n_mis++;
        $display("FAIL b_handshake: got bready=0 for 200 cycles, required 1");
        bvalid = 0;
        return;
      end
      exp_q.push_back(mk_wr(bid, bresp));
      @(posedge aclk); #1;
    end
    bvalid = 0;
  endtask

  task automatic test_reset();
    bvalid = 0; rvalid = 0; rlast = 0; cmpl_ready = 1;
    bid = '0; bresp = '0; rid = '0; rdata = '0; rresp = '0;
    aresetn = 0;
    #3;
    n_cmp += 5;
    if (cmpl_valid !== 1'b0) begin n_mis++; $display("FAIL rst_valid: got %b required 0", cmpl_valid); end
    if (cmpl_entry !== '0) begin n_mis++; $display("FAIL rst_entry: got %h required 0", cmpl_entry); end
    if (bready !== 1'b0) begin n_mis++; $display("FAIL rst_bready: got %b required 0", bready); end
    if (rready !== 1'b0) begin n_mis++; $display("FAIL rst_rready: got %b required 0", rready); end
    if (rd_burst_act !== 1'b0) begin n_mis++; $display("FAIL rst_burst: got %b required 0", rd_burst_act); end
    do_reset();
  endtask

  task automatic test_single_b();
    bvalid = 1; bid = 3; bresp = RESP_OKAY;
    @(negedge aclk);
    n_cmp++;
    if (bready !== 1'b1) begin n_mis++; $display("FAIL single_b_bready: got %b required 1", bready); end
    exp_q.push_back(mk_wr(4'd3, RESP_OKAY));
    @(posedge aclk); #1;
    bvalid = 0;
    n_cmp++;
    if (cmpl_valid !== 1'b1) begin n_mis++; $display("FAIL single_b_latency: got %b required 1", cmpl_valid); end
    wait_drain();
  endtask

  task automatic test_read_burst();
    int stalls;
    int base = log_q.size();
    r_burst(4'd5, 4, 64'h11, -1, RESP_OKAY, stalls);
    wait_drain();
    n_cmp++;
    if (stalls != 0) begin n_mis++; $display("FAIL read_throughput: got %0d stalls required 0", stalls); end
    n_cmp++;
    if (log_q.size() != base + 4) begin
      n_mis++; $display("FAIL read_count: got %0d required %0d", log_q.size() - base, 4);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (log_q[base+i].last !== (i == 3)) begin
          n_mis++; $display("FAIL read_last %0d: got %b required %b", i, log_q[base+i].last, (i == 3));
        end
      end
    end
  endtask

  task automatic test_read_error();
    int stalls;
    int base = log_q.size();
    r_burst(4'd6, 4, 64'h100, 1, RESP_OKAY, stalls);
    r_burst(4'd2, 2, 64'h55, -1, RESP_EXOKAY, stalls);
    wait_drain();
    n_cmp++;
    if (log_q.size() != base + 6) begin
      n_mis++; $display("FAIL err_count: got %0d required 6", log_q.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (log_q[base+i].burst_err !== (i >= 1 && i <= 3)) begin
          n_mis++;
          $display("FAIL burst_err %0d: got %b required %b", i, log_q[base+i].burst_err,
                   (i >= 1 && i <= 3));
        end
      end
    end
  endtask

  task automatic test_arbitration(input int beats);
    int stalls;
    int base;
    int total;
    do_reset();
    base = log_q.size();
    total = 2 * 1 + 2 * beats;
    if (beats == 1) total = 8;
    fork
      b_stream((beats == 1) ? 4 : 2, 4'd8, RESP_OKAY);
      begin
        for (int j = 0; j < ((beats == 1) ? 4 : 2); j++)
          r_burst(4'd1 + 4'(j), beats, 64'h1000 * (j + 1), -1, RESP_OKAY, stalls);
      end
    join
    wait_drain();
    n_cmp++;
    if (log_q.size() != base + total) begin
      n_mis++; $display("FAIL arb_count: got %0d required %0d", log_q.size() - base, total);
    end else begin
      for (int i = 0; i < total; i++) begin
        n_cmp++;
        if (log_q[base+i].is_wr !== ((i % (beats + 1)) == 0)) begin
          n_mis++;
          $display("FAIL arb_order %0d (beats=%0d): got is_wr=%b required %b", i, beats,
                   log_q[base+i].is_wr, ((i % (beats + 1)) == 0));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int stalls;
    int base = log_q.size();
    fork
      r_burst(4'd7, 6, 64'h700, -1, RESP_OKAY, stalls);
      begin
        completion_t held;
        int w = 0;
        while (log_q.size() < base + 2 && w < 50) begin
          @(posedge aclk);
          w++;
        end
        @(posedge aclk); #1;
        cmpl_ready = 0;
        for (int i = 0; i < 5; i++) begin
          @(negedge aclk);
          if (i == 0) held = cmpl_entry;
          n_cmp++;
          if (rready !== 1'b0 || cmpl_valid !== 1'b1 || cmpl_entry !== held) begin
            n_mis++;
            $display("FAIL hold %0d: got rready=%b valid=%b entry=%h required 0/1/%h",
                     i, rready, cmpl_valid, cmpl_entry, held);
          end
        end
        @(posedge aclk); #1;
        cmpl_ready = 1;
      end
    join
    wait_drain();
    n_cmp++;
    if (log_q.size() != base + 6) begin
      n_mis++; $display("FAIL bp_count: got %0d required 6", log_q.size() - base);
    end
  endtask

  task automatic test_reset_mid_burst();
    int stalls;
    int base;
    rvalid = 1; rid = 4'd9; rdata = 64'hA1; rresp = RESP_OKAY; rlast = 0;
    @(negedge aclk);
    n_cmp++;
    if (rready !== 1'b1) begin n_mis++; $display("FAIL mid_rst_rready: got %b required 1", rready); end
    exp_q.push_back(mk_rd(4'd9, RESP_OKAY, 64'hA1, 1'b0, 0, 1'b0));
    @(posedge aclk); #1;
    rdata = 64'hA2;
    @(negedge aclk); #1;
    n_cmp++;
    if (rd_burst_act !== 1'b1) begin n_mis++; $display("FAIL mid_rst_pre: got %b required 1", rd_burst_act); end
    aresetn = 0;
    #1;
    n_cmp += 2;
    if (cmpl_valid !== 1'b0) begin n_mis++; $display("FAIL mid_rst_valid: got %b required 0", cmpl_valid); end
    if (rd_burst_act !== 1'b0) begin n_mis++; $display("FAIL mid_rst_burst: got %b required 0", rd_burst_act); end
    rvalid = 0;
    exp_q.delete();
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
    @(posedge aclk); #1;
    base = log_q.size();
    r_burst(4'd10, 3, 64'h300, -1, RESP_OKAY, stalls);
    wait_drain();
    n_cmp++;
    if (log_q.size() != base + 3 || log_q[base].beat_idx !== '0) begin
      n_mis++; $display("FAIL mid_rst_restart: got %0d entries, required 3 starting at beat_idx 0",
                        log_q.size() - base);
    end
  endtask

  task automatic test_saturation();
    int stalls;
    r_burst(4'd11, 260, 64'h0, -1, RESP_OKAY, stalls);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_single_b();
    test_read_burst();
    test_read_error();
    test_arbitration(1);
    test_arbitration(3);
    test_backpressure();
    test_reset_mid_burst();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
